gps_uart_rx: RTL

- 8N1 UART receiver feeding the GPS NMEA sentence parser with one ASCII byte per frame.
- Delivers data_rx plus an rx_int envelope. The parser treats the falling edge of rx_int as "byte complete" and samples data_rx after its own 2-flop edge detector.
- Sits between the GPS module TX pin and the NMEA parser.

---
 rtl/gps_pkg.sv | 21 ++
 rtl/gps_uart_baud_cnt.sv | 45 ++++
 rtl/gps_uart_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gps_pkg.sv
// Types and constants shared by the GPS receive path: the one-hot UART RX
// state encoding, the NMEA bytes the parser relies on, and a 2-of-3 vote helper.
package gps_pkg;

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      START = 5'b00010,
      DATA  = 5'b00100,
      STOP  = 5'b01000,
      BREAK = 5'b10000
   } rx_state_e;

   localparam logic [7:0] ASCII_DOLLAR = 8'h24;
   localparam logic [7:0] ASCII_COMMA  = 8'h2C;
   localparam logic [7:0] ASCII_NUL    = 8'h00;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/gps_uart_baud_cnt.sv
// Free-running bit-period counter (0..DIV-1, wraps) with synchronous clear,
// a mid-bit strobe at count MID and a terminal strobe at count DIV-1.
module gps_uart_baud_cnt #(
   parameter int DIV = 10,
   parameter int MID = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   output logic mid_o,
   output logic term_o
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] MID_V  = W'(MID);
   localparam logic [W-1:0] TERM_V = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear has priority, otherwise wrap at the end of the bit period.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q == TERM_V) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign mid_o  = (cnt_q == MID_V);
   assign term_o = (cnt_q == TERM_V);

endmodule

// File: rtl/gps_uart_rx.sv
// 8N1 UART receiver for the NMEA parser: data_rx is valid from each rx_int fall.
// Define GPS_UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module gps_uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] data_rx,
   output logic       rx_int,
   output logic       frame_err
);

   import gps_pkg::*;

   localparam int BAUD_DIV = CLK_FREQ / BAUD;

   logic       sync1_q, rxd_s_q, rxd_prev_q;
   logic       fall_s, bit_s, mid_s, term_s, cnt_clr_s;
   rx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d, data_q, data_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       rx_int_q, rx_int_d, frame_err_q, frame_err_d;

   // Two-flop synchroniser plus one delayed copy for fall detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync1_q    <= uart_rxd;
         rxd_s_q    <= sync1_q;
         rxd_prev_q <= rxd_s_q;
      end
   end

   assign fall_s = rxd_prev_q & ~rxd_s_q;

`ifdef GPS_UART_RX_MAJORITY_EN
   // Decisions move to mid+1 so the vote window is mid-1, mid, mid+1.
   localparam int MID_SAMPLE = BAUD_DIV / 2;
   logic rxd_d2_q;

   // Second delayed copy of the line feeding the vote.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxd_d2_q <= 1'b1;
      end else begin
         rxd_d2_q <= rxd_prev_q;
      end
   end

   assign bit_s = maj3(rxd_s_q, rxd_prev_q, rxd_d2_q);
`else
   localparam int MID_SAMPLE = BAUD_DIV / 2 - 1;
   assign bit_s = rxd_s_q;
`endif

   gps_uart_baud_cnt #(
      .DIV (BAUD_DIV),
      .MID (MID_SAMPLE)
   ) u_baud_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr_s),
      .mid_o  (mid_s),
      .term_o (term_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fall_s) state_d = START; else state_d = IDLE;
         START:   if (mid_s) state_d = bit_s ? IDLE : DATA; else state_d = START;
         DATA:    if (term_s && (bit_idx_q == 3'd7)) state_d = STOP; else state_d = DATA;
         STOP:    if (term_s) state_d = bit_s ? IDLE : BREAK; else state_d = STOP;
         BREAK:   if (rxd_s_q) state_d = IDLE; else state_d = BREAK;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values; data_rx only moves when rx_int drops.
   always_comb begin
      cnt_clr_s   = 1'b0;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      data_d      = data_q;
      rx_int_d    = rx_int_q;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clr_s = fall_s;
            rx_int_d  = 1'b0;
         end
         START: begin
            if (mid_s && !bit_s) begin
               rx_int_d  = 1'b1;
               cnt_clr_s = 1'b1;
               bit_idx_d = 3'd0;
            end else begin
               rx_int_d  = 1'b0;
            end
         end
         DATA: begin
            if (term_s) begin
               shift_d   = {bit_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               shift_d   = shift_q;
            end
         end
         STOP: begin
            if (term_s) begin
               rx_int_d = 1'b0;
               if (bit_s) begin
                  data_d = shift_q;
               end else begin
                  data_d      = ASCII_NUL;
                  frame_err_d = 1'b1;
               end
            end else begin
               rx_int_d = 1'b1;
            end
         end
         BREAK:   rx_int_d = 1'b0;
         default: rx_int_d = 1'b0;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q     <= 8'h00;
         bit_idx_q   <= 3'd0;
         data_q      <= 8'h00;
         rx_int_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         data_q      <= data_d;
         rx_int_q    <= rx_int_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data_rx   = data_q;
   assign rx_int    = rx_int_q;
   assign frame_err = frame_err_q;

endmodule
